// File: rtl/step_cnt_pkg.sv
// Shared types, default parameters and helpers for step_pattern_counter.
//
// Contents:
//   dir_e       count direction (DIR_UP / DIR_DOWN)
//   Def*        default widths used by the counter and its phase generator
//   next_phase  phase advance rule for one enabled cycle
package step_cnt_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefStepW  = 4;
  localparam int unsigned DefPhaseW = 2;

  // Period 0 pins the phase at 0; a phase at or beyond the last slot of the
  // period (e.g. after period was lowered) returns to 0.
  function automatic int unsigned next_phase(int unsigned phase, int unsigned period);
    if (period == 0 || phase >= period - 1) begin
      return 0;
    end
    return phase + 1;
  endfunction

endpackage

// File: rtl/step_phase_gen.sv
// Phase register and step selection for step_pattern_counter.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (phase -> 0)
//   load        counter load this cycle (phase -> 0), priority over en
//   en          counter advances this cycle
//   clr         counter wraps this cycle; phase returns to 0 instead of advancing
//   period      phases per period, 0 = step_a only
//   step_a      normal step size
//   step_b      step size on the last phase of the period
//   phase       current phase index
//   step        step selected for the current phase
//   phase_last  current phase is the last one of the period
module step_phase_gen
  import step_cnt_pkg::*;
#(
  parameter int unsigned STEP_W  = DefStepW,
  parameter int unsigned PHASE_W = DefPhaseW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic               clr,
  input  logic [PHASE_W-1:0] period,
  input  logic [STEP_W-1:0]  step_a,
  input  logic [STEP_W-1:0]  step_b,
  output logic [PHASE_W-1:0] phase,
  output logic [STEP_W-1:0]  step,
  output logic               phase_last
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_last = (period != '0) && (phase_q == period - PHASE_W'(1));
    step       = phase_last ? step_b : step_a;
  end

  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = clr ? '0 : PHASE_W'(next_phase(32'(phase_q), 32'(period)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

  // The last-phase flag and the step mux must never disagree.
  assert property (@(posedge clk) disable iff (rst) phase_last |-> (step == step_b));

endmodule

// File: rtl/step_pattern_counter.sv
// Programmable-step up/down counter with runtime limit and terminal-count pulse.
// Each enabled cycle the count moves by step_a, or by step_b on the last phase
// of each period, and wraps (or saturates) at 0 / limit.
//
// Optional feature: define STEP_PATTERN_CNT_SAT_EN to add input sat; with sat=1
// the count saturates at the bound instead of wrapping.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   sat       (STEP_PATTERN_CNT_SAT_EN only) saturate instead of wrap
//   en        advance this cycle
//   load      load load_val this cycle, priority over en
//   load_val  value for load
//   dir       0 = up, 1 = down
//   step_a    normal step size
//   step_b    step size on the last phase of each period
//   period    phases per period, 0 = step_a only
//   limit     inclusive upper bound of the count
//   count     current count
//   phase     current phase index
//   wrap      one-cycle pulse on the cycle the count wraps
module step_pattern_counter
  import step_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned STEP_W  = DefStepW,
  parameter int unsigned PHASE_W = DefPhaseW
) (
  input  logic               clk,
  input  logic               rst,
`ifdef STEP_PATTERN_CNT_SAT_EN
  input  logic               sat,
`endif
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  input  logic [STEP_W-1:0]  step_a,
  input  logic [STEP_W-1:0]  step_b,
  input  logic [PHASE_W-1:0] period,
  input  logic [WIDTH-1:0]   limit,
  output logic [WIDTH-1:0]   count,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [STEP_W-1:0] step;
  logic              phase_last;
  logic [WIDTH:0]    step_ext, sum;
  logic              up_over, down_under;
  logic              hit;
  logic              sat_on;
  logic              phase_clr;
  dir_e              dir_s;

`ifdef STEP_PATTERN_CNT_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  assign dir_s = dir_e'(dir);

  step_phase_gen #(
    .STEP_W  (STEP_W),
    .PHASE_W (PHASE_W)
  ) u_phase_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .en         (en),
    .clr        (phase_clr),
    .period     (period),
    .step_a     (step_a),
    .step_b     (step_b),
    .phase      (phase),
    .step       (step),
    .phase_last (phase_last)
  );

  // One extra bit so the up-sum cannot alias back below limit.
  always_comb begin
    step_ext   = (WIDTH+1)'(step);
    sum        = {1'b0, count_q} + step_ext;
    up_over    = sum > {1'b0, limit};
    down_under = {1'b0, count_q} < step_ext;
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    hit     = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir_s == DIR_UP) begin
        if (up_over) begin
          hit = 1'b1;
          if (sat_on) begin
            count_d = limit;
            wrap_d  = (count_q != limit);  // pulse only when first reaching the bound
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        if (down_under) begin
          hit = 1'b1;
          if (sat_on) begin
            count_d = '0;
            wrap_d  = (count_q != '0);
          end else begin
            count_d = limit;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - step_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Saturation keeps the phase sequence running; a true wrap restarts it.
  assign phase_clr = hit & ~sat_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_step_pattern_counter.sv
module tb_step_pattern_counter;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst, en, load, dir;
  logic [W-1:0]  load_val, limit;
  logic [SW-1:0] step_a, step_b;
  logic [PW-1:0] period;
  logic [W-1:0]  count;
  logic [PW-1:0] phase;
  logic          wrap;
  logic          sat;

  always #5 clk = ~clk;

  step_pattern_counter #(
    .WIDTH   (W),
    .STEP_W  (SW),
    .PHASE_W (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef STEP_PATTERN_CNT_SAT_EN
    .sat      (sat),
`endif
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .step_a   (step_a),
    .step_b   (step_b),
    .period   (period),
    .limit    (limit),
    .count    (count),
    .phase    (phase),
    .wrap     (wrap)
  );

  typedef struct {
    int    cnt;
    int    ph;
    bit    wr;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state held as plain integers.
  int    m_cnt = 0;
  int    m_ph  = 0;
  string cur_tag = "init";

  // Spec-level next state: priority rst > load > en > hold.
  task automatic model_step(input bit r, input bit ld, input int lv, input bit e, input bit d,
                            input int sa, input int sb, input int per, input int lim,
                            input bit s, output bit wr);
    int stp, nph;
    wr = 1'b0;
    if (r) begin
      m_cnt = 0; m_ph = 0;
    end else if (ld) begin
      m_cnt = lv; m_ph = 0;
    end else if (e) begin
      stp = (per != 0 && m_ph == per - 1) ? sb : sa;
      nph = (per == 0 || m_ph >= per - 1) ? 0 : m_ph + 1;
      if (!d) begin
        if (m_cnt + stp > lim) begin
          if (s) begin wr = (m_cnt != lim); m_cnt = lim; m_ph = nph; end
          else   begin wr = 1'b1; m_cnt = 0; m_ph = 0; end
        end else begin
          m_cnt = m_cnt + stp; m_ph = nph;
        end
      end else begin
        if (m_cnt < stp) begin
          if (s) begin wr = (m_cnt != 0); m_cnt = 0; m_ph = nph; end
          else   begin wr = 1'b1; m_cnt = lim; m_ph = 0; end
        end else begin
          m_cnt = m_cnt - stp; m_ph = nph;
        end
      end
    end
  endtask

  // Apply one cycle of stimulus and queue the expected registered response.
  task automatic drive(input bit r, input bit ld, input int lv, input bit e, input bit d,
                       input int sa, input int sb, input int per, input int lim, input bit s);
    bit   wr;
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; load_val = W'(lv); en = e; dir = d;
    step_a = SW'(sa); step_b = SW'(sb); period = PW'(per); limit = W'(lim); sat = s;
`ifndef STEP_PATTERN_CNT_SAT_EN
    s = 1'b0;
`endif
    model_step(r, ld, lv, e, d, sa, sb, per, lim, s, wr);
    x.cnt = m_cnt; x.ph = m_ph; x.wr = wr; x.tag = cur_tag;
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle the DUT presents registered outputs; pop and compare.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++;
      if (int'(count) != x.cnt || int'(phase) != x.ph || wrap !== x.wr) begin
        n_fail++;
        $display("FAIL %s: got count=%0d phase=%0d wrap=%b, expected count=%0d phase=%0d wrap=%b",
                 x.tag, count, phase, wrap, x.cnt, x.ph, x.wr);
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0; load_val = '0;
    step_a = '0; step_b = '0; period = '0; limit = '0; sat = 1'b0;

    // Reset state.
    cur_tag = "reset";
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Legacy +1/+2 pattern up to the 254 wrap.
    cur_tag = "legacy";
    for (int i = 0; i < 175; i++) drive(0, 0, 0, 1, 0, 1, 2, 2, 254, 0);

    // Down wrap: 3,1,10,8.
    cur_tag = "down_wrap";
    drive(0, 1, 3, 0, 1, 2, 2, 0, 10, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1, 2, 2, 0, 10, 0);

    // Priority: rst over load/en, then load over en.
    cur_tag = "priority";
    drive(1, 1, 8'h33, 1, 0, 1, 1, 3, 200, 0);
    drive(0, 1, 8'h55, 1, 0, 1, 1, 3, 200, 0);

    // Hold, then lower the limit below the count.
    cur_tag = "hold";
    drive(0, 1, 7, 0, 0, 2, 3, 3, 50, 0);
    drive(0, 0, 0, 1, 0, 2, 3, 3, 50, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 2, 3, 3, 50, 0);
    cur_tag = "limit_drop";
    drive(0, 0, 0, 1, 0, 2, 3, 3, 4, 0);
    drive(0, 0, 0, 1, 0, 2, 3, 3, 4, 0);

    // Zero step above limit still wraps; zero step inside limit only moves phase.
    cur_tag = "zero_step";
    drive(0, 1, 20, 0, 0, 0, 0, 3, 10, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 3, 10, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0, 3, 10, 0);

    // Period lowered below current phase.
    cur_tag = "period_drop";
    drive(0, 1, 0, 0, 0, 1, 1, 3, 200, 0);
    drive(0, 0, 0, 1, 0, 1, 1, 3, 200, 0);
    drive(0, 0, 0, 1, 0, 1, 1, 3, 200, 0);
    drive(0, 0, 0, 1, 0, 1, 1, 1, 200, 0);
    drive(0, 0, 0, 1, 0, 1, 1, 1, 200, 0);

`ifdef STEP_PATTERN_CNT_SAT_EN
    cur_tag = "sat_up";
    drive(1, 0, 0, 0, 0, 3, 3, 0, 7, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 3, 3, 0, 7, 1);
    cur_tag = "sat_down";
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 3, 3, 2, 7, 1);
`endif

    // Randomized traffic.
    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, e, d, s;
      int lim;
      r   = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 6);
      e   = ($urandom_range(0, 99) < 85);
      d   = (((i / 40) % 2) == 1) ^ ($urandom_range(0, 99) < 5);
      s   = ($urandom_range(0, 3) == 0);
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      drive(r, ld, $urandom_range(0, 255), e, d, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3), lim, s);
    end

    // Drain and confirm every expectation was consumed.
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_pattern_counter.md
Name: step_pattern_counter

Overview:
Parametrised, programmable-step counter, generalising the team's fixed "+1/+2, wrap at 254" counter.
- Each enabled cycle it adds or subtracts one of two runtime step sizes.
- A phase counter selects the step: step_b on the last phase of each period, step_a otherwise.
- Wraps at a runtime limit, in either direction, and pulses a terminal-count flag.
- Used as a stride/address generator and event pacer in the datapath.

Parameters:
- WIDTH, 8, width of the count, load value and limit.
- STEP_W, 4, width of the step_a/step_b inputs (STEP_W <= WIDTH).
- PHASE_W, 2, width of the period input and phase output.

Ports:
- clk  in  1  clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance the counter this cycle.
- load  in  1  load load_val this cycle; priority over en.
- load_val  in  WIDTH  value for load.
- dir  in  1  0 = count up, 1 = count down.
- step_a  in  STEP_W  normal step size.
- step_b  in  STEP_W  step size on the last phase of each period.
- period  in  PHASE_W  phases per period; 0 means step_a only.
- limit  in  WIDTH  inclusive upper bound of the count.
- count  out  WIDTH  current count.
- phase  out  PHASE_W  current phase index.
- wrap  out  1  one-cycle pulse on the cycle count wraps.

Behaviour:
- Reset: one clock with rst=1 gives count=0, phase=0, wrap=0. rst has priority over load and en.
- Reset mid-operation: state is lost, with no partial update.
- Priority each clock: rst > load > en > hold.
- load: count<=load_val, phase<=0, wrap<=0. load_val above limit is accepted; the next enabled up step wraps.
- Hold (en=0, load=0): count and phase unchanged, wrap<=0.
- Step selection: step = (period!=0 && phase==period-1) ? step_b : step_a, zero-extended to WIDTH+1 bits.
- Phase update when enabled: phase <= (period==0 || phase>=period-1) ? 0 : phase+1.
  - A period lowered below the current phase causes a return to 0 on the next enabled cycle.
- Up (dir=0): sum = count+step in WIDTH+1 bits.
  - If sum > limit: count<=0, phase<=0, wrap<=1.
  - Else count<=sum[WIDTH-1:0], wrap<=0.
- Down (dir=1):
  - If count < step: count<=limit, phase<=0, wrap<=1.
  - Else count<=count-step, wrap<=0.
- step=0: count holds while phase still advances. A wrap cannot occur unless count > limit.
- Runtime changes: limit, dir, step_a, step_b and period are sampled every cycle and act on the next enabled update.
- Latency: all outputs are registered, so an input change shows on the outputs one clock later. No combinational path from inputs to outputs.
- wrap is exactly one cycle wide unless a wrap condition recurs on consecutive enabled cycles.

Optional Feature:
- Macro: STEP_PATTERN_CNT_SAT_EN.
- Defined: adds input port sat (1 bit). When sat=1, count saturates instead of wrapping:
  - Up: count<=limit.
  - Down: count<=0.
  - wrap pulses only on the first cycle count reaches the bound; phase still advances normally.
- Undefined: port sat is absent and the counter always wraps as above.

Decomposition:
- Package step_cnt_pkg:
  - typedef enum logic {DIR_UP=1'b0, DIR_DOWN=1'b1} dir_e.
  - Default-parameter localparams.
  - A function next_phase(phase, period).
- One natural sub-module, step_phase_gen: owns the phase register and step selection, and outputs the selected step plus a phase_last flag.
- The top block owns count, wrap and the compare/arithmetic.

Test Plan:
1. Legacy pattern: step_a=1, step_b=2, period=2, limit=254, dir=0, en=1 from reset -> count 0,1,3,4,6,... and wrap asserted on the step whose sum exceeds 254, then count=0.
2. Down wrap: load=1 with load_val=3, then en=1, dir=1, step_a=2, period=0, limit=10 -> count 3,1,10 with wrap=1 on the cycle count=10, then 8.
3. Priority: rst=1, load=1 and en=1 together -> count=0. Next cycle load=1 (load_val=0x55) with en=1 -> count=0x55, phase=0.
4. Hold and limit change: en=0 for 5 cycles -> count/phase unchanged and wrap=0. Then limit=4 while count=9 -> the first enabled up step wraps to 0.
5. Sat macro: with STEP_PATTERN_CNT_SAT_EN, sat=1, step_a=3, limit=7, dir=0 -> count 0,3,6,7,7 with wrap high only on the first 7.
